// File: rtl/wb_cmd_master_if.sv
// Wishbone initiator-side bus bundle used between wb_cmd_master and the FPGA register/FIFO responder.
interface wb_cmd_master_if #(
    parameter int ADDRWIDTH = 9,
    parameter int DATAWIDTH = 32
);
    logic [ADDRWIDTH-1:0] WBm_ADR_o;
    logic                 WBm_CYC_o;
    logic                 WBm_STB_o;
    logic                 WBm_WE_o;
    logic                 WBm_RD_o;
    logic [3:0]           WBm_BYTE_STB_o;
    logic [DATAWIDTH-1:0] WBm_DAT_o;
    logic [DATAWIDTH-1:0] WBm_DAT_i;
    logic                 WBm_ACK_i;

    modport master (
        output WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o, WBm_BYTE_STB_o, WBm_DAT_o,
        input  WBm_DAT_i, WBm_ACK_i
    );

    modport slave (
        input  WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o, WBm_BYTE_STB_o, WBm_DAT_o,
        output WBm_DAT_i, WBm_ACK_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Turns a command/response stream into repeated single-beat Wishbone accesses,
// with an idle gap after each access and a timeout for silent targets.
module wb_cmd_master #(
    parameter int ADDRWIDTH = 9,
    parameter int DATAWIDTH = 32,
    parameter int IDLE_GAP  = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic [DATAWIDTH-1:0] cmd_dat_i,
    input  logic [3:0]           cmd_be_i,
    input  logic [7:0]           cmd_len_i,
    input  logic                 cmd_inc_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 rsp_last_o,
    output logic                 busy_o,
    wb_cmd_master_if.master      wb
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, GAP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST     = 4'(IDLE_GAP - 1);

    state_t               state;
    logic                 we_q;
    logic                 inc_q;
    logic [ADDRWIDTH-1:0] adr_q;
    logic [DATAWIDTH-1:0] dat_q;
    logic [3:0]           be_q;
    logic [7:0]           remaining;
    logic [7:0]           wait_cnt;
    logic [3:0]           gap_cnt;
    logic                 cyc_q;
    logic                 stb_q;
    logic                 wbwe_q;
    logic                 rd_q;

    assign cmd_ready_o       = (state == IDLE) && !WBs_RST_i;
    assign busy_o            = (state != IDLE);
    assign wb.WBm_ADR_o      = adr_q;
    assign wb.WBm_DAT_o      = dat_q;
    assign wb.WBm_BYTE_STB_o = be_q;
    assign wb.WBm_CYC_o      = cyc_q;
    assign wb.WBm_STB_o      = stb_q;
    assign wb.WBm_WE_o       = wbwe_q;
    assign wb.WBm_RD_o       = rd_q;

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            inc_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            be_q        <= '0;
            remaining   <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            wbwe_q      <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            rsp_last_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        we_q      <= cmd_we_i;
                        inc_q     <= cmd_inc_i;
                        adr_q     <= cmd_adr_i;
                        dat_q     <= cmd_dat_i;
                        be_q      <= cmd_be_i;
                        remaining <= (cmd_len_i == 8'd0) ? 8'd1 : cmd_len_i;
                        wait_cnt  <= '0;
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        wbwe_q    <= cmd_we_i;
                        rd_q      <= !cmd_we_i;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // An ACK in the final allowed cycle still wins over the timeout.
                    if (wb.WBm_ACK_i) begin
                        rsp_dat_o   <= we_q ? '0 : wb.WBm_DAT_i;
                        rsp_err_o   <= 1'b0;
                        rsp_last_o  <= (remaining == 8'd1);
                        rsp_valid_o <= 1'b1;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        wbwe_q      <= 1'b0;
                        rd_q        <= 1'b0;
                        state       <= RSP;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_last_o  <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        remaining   <= 8'd1;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        wbwe_q      <= 1'b0;
                        rd_q        <= 1'b0;
                        state       <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b0;
                        rsp_last_o  <= 1'b0;
                        remaining   <= remaining - 8'd1;
                        gap_cnt     <= '0;
                        if (inc_q && we_q) begin
                            dat_q <= dat_q + 1'b1;
                        end
                        if (IDLE_GAP != 0) begin
                            state <= GAP;
                        end else if (remaining > 8'd1) begin
                            wait_cnt <= '0;
                            cyc_q    <= 1'b1;
                            stb_q    <= 1'b1;
                            wbwe_q   <= we_q;
                            rd_q     <= !we_q;
                            state    <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (remaining != 8'd0) begin
                            wait_cnt <= '0;
                            cyc_q    <= 1'b1;
                            stb_q    <= 1'b1;
                            wbwe_q   <= we_q;
                            rd_q     <= !we_q;
                            state    <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: a behavioural register/FIFO responder plus a queue of
// expected responses computed from the command rules, checked by an independent monitor.
module tb_wb_cmd_master;

    localparam int ADDRWIDTH = 9;
    localparam int DATAWIDTH = 32;
    localparam int IDLE_GAP  = 2;
    localparam int TIMEOUT   = 16;
    localparam logic [31:0] ID_VALUE = 32'hF1F07E57;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        last;
    } rsp_t;

    logic        WBs_CLK_i = 1'b0;
    logic        WBs_RST_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [8:0]  cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [3:0]  cmd_be_i = '0;
    logic [7:0]  cmd_len_i = '0;
    logic        cmd_inc_i = 1'b0;
    logic        rsp_valid_o;
    wire         rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_last_o;
    logic        busy_o;

    logic manualReady = 1'b1;
    logic rndReady = 1'b1;
    logic randomMode = 1'b0;
    bit   slaveNoAck = 1'b0;

    int checks = 0;
    int failures = 0;

    rsp_t        expQ[$];
    rsp_t        headExp;
    logic [31:0] modelMem [256] = '{default: 32'h0};
    logic [31:0] modelFifo[$];
    logic [31:0] slaveMem [256] = '{default: 32'h0};
    logic [31:0] slaveFifo[$];

    bit prevHeld = 1'b0;
    bit ackPrev = 1'b0;
    bit cycPrev = 1'b0;
    int lowRun = 1000;

    assign rsp_ready_i = randomMode ? rndReady : manualReady;

    always #5 WBs_CLK_i = ~WBs_CLK_i;

    wb_cmd_master_if #(.ADDRWIDTH(ADDRWIDTH), .DATAWIDTH(DATAWIDTH)) wb ();

    wb_cmd_master #(
        .ADDRWIDTH(ADDRWIDTH),
        .DATAWIDTH(DATAWIDTH),
        .IDLE_GAP (IDLE_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .WBs_CLK_i  (WBs_CLK_i),
        .WBs_RST_i  (WBs_RST_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_adr_i  (cmd_adr_i),
        .cmd_dat_i  (cmd_dat_i),
        .cmd_be_i   (cmd_be_i),
        .cmd_len_i  (cmd_len_i),
        .cmd_inc_i  (cmd_inc_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .rsp_last_o (rsp_last_o),
        .busy_o     (busy_o),
        .wb         (wb)
    );

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] dat,
                                               input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = dat[8*b +: 8];
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Responder: address 0 is a read-only ID, 0x001-0x0FF plain registers, 0x100-0x1FF one shared FIFO.
    always @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            wb.WBm_ACK_i <= 1'b0;
        end else if (wb.WBm_CYC_o && wb.WBm_STB_o && !wb.WBm_ACK_i && !slaveNoAck) begin
            wb.WBm_ACK_i <= 1'b1;
            if (wb.WBm_ADR_o[8]) begin
                if (wb.WBm_WE_o)
                    slaveFifo.push_back(mergeBytes(32'h0, wb.WBm_DAT_o, wb.WBm_BYTE_STB_o));
                else if (wb.WBm_RD_o)
                    wb.WBm_DAT_i <= (slaveFifo.size() > 0) ? slaveFifo.pop_front() : 32'h0;
            end else begin
                if (wb.WBm_WE_o) begin
                    if (wb.WBm_ADR_o != 9'h0)
                        slaveMem[wb.WBm_ADR_o[7:0]] <= mergeBytes(slaveMem[wb.WBm_ADR_o[7:0]],
                                                                  wb.WBm_DAT_o, wb.WBm_BYTE_STB_o);
                end else if (wb.WBm_RD_o) begin
                    wb.WBm_DAT_i <= (wb.WBm_ADR_o == 9'h0) ? ID_VALUE : slaveMem[wb.WBm_ADR_o[7:0]];
                end
            end
        end else begin
            wb.WBm_ACK_i <= 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge WBs_CLK_i);
            #1 rndReady = ($urandom_range(3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every handshake and watches bus/response protocol rules.
    always @(negedge WBs_CLK_i) begin
        if (!WBs_RST_i) begin
            if (rsp_valid_o && rsp_ready_i) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rsp actual dat=0x%08h err=%0b last=%0b expected none",
                             rsp_dat_o, rsp_err_o, rsp_last_o);
                end else begin
                    headExp = expQ.pop_front();
                    checkOutput("rsp_dat", rsp_dat_o, headExp.dat);
                    checkOutput("rsp_err", 32'(rsp_err_o), 32'(headExp.err));
                    checkOutput("rsp_last", 32'(rsp_last_o), 32'(headExp.last));
                end
            end else if (rsp_valid_o && expQ.size() > 0) begin
                checkOutput("held_dat", rsp_dat_o, expQ[0].dat);
                checkOutput("held_last", 32'(rsp_last_o), 32'(expQ[0].last));
            end
            if (prevHeld) checkOutput("held_valid", 32'(rsp_valid_o), 32'd1);
            prevHeld = rsp_valid_o && !rsp_ready_i;
            if (rsp_valid_o) checkOutput("stb_during_rsp", 32'(wb.WBm_STB_o), 32'd0);
            if (ackPrev) checkOutput("stb_after_ack", 32'(wb.WBm_STB_o), 32'd0);
            ackPrev = wb.WBm_ACK_i && wb.WBm_STB_o;
            if (wb.WBm_CYC_o) begin
                if (!cycPrev && lowRun < 1000) checkOutput("cyc_idle_gap", 32'(lowRun >= IDLE_GAP), 32'd1);
                lowRun = 0;
            end else if (lowRun < 1000) begin
                lowRun++;
            end
            cycPrev = wb.WBm_CYC_o;
        end else begin
            prevHeld = 1'b0;
            ackPrev  = 1'b0;
            cycPrev  = 1'b0;
            lowRun   = 1000;
        end
    end

    // Expected responses for one command, derived from the access rules and the responder's map.
    task automatic modelCommand(input logic we, input logic [8:0] adr, input logic [31:0] dat,
                                input logic [3:0] be, input logic [7:0] len);
        int   n;
        rsp_t r;
        n = (len == 8'd0) ? 1 : int'(len);
        if (slaveNoAck) begin
            r.dat = 32'h0; r.err = 1'b1; r.last = 1'b1;
            expQ.push_back(r);
            return;
        end
        for (int i = 0; i < n; i++) begin
            r.err  = 1'b0;
            r.last = (i == n - 1);
            if (we) begin
                r.dat = 32'h0;
                if (adr[8]) modelFifo.push_back(mergeBytes(32'h0, dat + 32'(i), be));
                else if (adr != 9'h0) modelMem[adr[7:0]] = mergeBytes(modelMem[adr[7:0]], dat + 32'(i), be);
            end else if (adr[8]) begin
                r.dat = (modelFifo.size() > 0) ? modelFifo.pop_front() : 32'h0;
            end else begin
                r.dat = (adr == 9'h0) ? ID_VALUE : modelMem[adr[7:0]];
            end
            expQ.push_back(r);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [8:0] adr, input logic [31:0] dat,
                                 input logic [3:0] be, input logic [7:0] len, input logic inc);
        int guard;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_be_i    = be;
        cmd_len_i   = len;
        cmd_inc_i   = inc;
        cmd_valid_i = 1'b1;
        guard = 0;
        @(negedge WBs_CLK_i);
        while (!cmd_ready_o && guard < 3000) begin
            @(negedge WBs_CLK_i);
            guard++;
        end
        if (!cmd_ready_o) begin
            checkOutput("cmd_accept_timeout", 32'(cmd_ready_o), 32'd1);
            cmd_valid_i = 1'b0;
            return;
        end
        modelCommand(we, adr, (inc && we) ? dat : dat, be, len);
        if (!inc) begin
            // Non-incrementing writes repeat the same word; fix up what the model pushed.
            if (we) begin
                int n;
                n = (len == 8'd0) ? 1 : int'(len);
                if (adr[8]) begin
                    for (int i = 0; i < n; i++) modelFifo[modelFifo.size() - n + i] = mergeBytes(32'h0, dat, be);
                end else if (adr != 9'h0) begin
                    modelMem[adr[7:0]] = mergeBytes(modelMem[adr[7:0]], dat, be);
                end
            end
        end
        @(posedge WBs_CLK_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic measureAccess(output int latency, output int stbCycles);
        latency = 0;
        stbCycles = 0;
        do begin
            @(negedge WBs_CLK_i);
            latency++;
            if (wb.WBm_STB_o) stbCycles++;
        end while (!rsp_valid_o && latency < 400);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((busy_o || expQ.size() != 0) && guard < 5000) begin
            @(negedge WBs_CLK_i);
            guard++;
        end
        checkOutput("idle_reached", 32'(busy_o || expQ.size() != 0), 32'd0);
        @(posedge WBs_CLK_i);
        #1;
    endtask

    initial begin
        int lat;
        int stbc;
        int r;
        logic [8:0] adr;

        repeat (3) @(posedge WBs_CLK_i);
        @(negedge WBs_CLK_i);
        checkOutput("reset_cmd_ready", 32'(cmd_ready_o), 32'd0);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_cyc", 32'(wb.WBm_CYC_o), 32'd0);
        checkOutput("reset_stb", 32'(wb.WBm_STB_o), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        @(posedge WBs_CLK_i);
        #1 WBs_RST_i = 1'b0;
        @(negedge WBs_CLK_i);
        checkOutput("ready_after_reset", 32'(cmd_ready_o), 32'd1);
        @(posedge WBs_CLK_i);
        #1;

        $display("[TB] ID register read");
        applyStimulus(1'b0, 9'h000, 32'h0, 4'hF, 8'd1, 1'b0);
        measureAccess(lat, stbc);
        checkOutput("read_latency", 32'(lat), 32'd3);
        checkOutput("read_stb_cycles", 32'(stbc), 32'd2);
        waitIdle();

        $display("[TB] register write then read");
        applyStimulus(1'b1, 9'h003, 32'h000000A5, 4'h1, 8'd1, 1'b0);
        applyStimulus(1'b0, 9'h003, 32'h0, 4'hF, 8'd0, 1'b0);
        waitIdle();

        $display("[TB] FIFO burst with incrementing data");
        applyStimulus(1'b1, 9'h100, 32'h00000010, 4'hF, 8'd4, 1'b1);
        applyStimulus(1'b0, 9'h100, 32'h0, 4'hF, 8'd4, 1'b0);
        waitIdle();

        $display("[TB] silent target timeout");
        slaveNoAck = 1'b1;
        applyStimulus(1'b0, 9'h004, 32'h0, 4'hF, 8'd3, 1'b0);
        measureAccess(lat, stbc);
        checkOutput("timeout_stb_cycles", 32'(stbc), 32'(TIMEOUT));
        checkOutput("timeout_err_cycle", 32'(lat), 32'(TIMEOUT + 1));
        waitIdle();
        slaveNoAck = 1'b0;

        $display("[TB] response backpressure");
        manualReady = 1'b0;
        applyStimulus(1'b0, 9'h003, 32'h0, 4'hF, 8'd2, 1'b0);
        measureAccess(lat, stbc);
        repeat (5) @(posedge WBs_CLK_i);
        #1 manualReady = 1'b1;
        waitIdle();

        $display("[TB] reset during request");
        applyStimulus(1'b0, 9'h005, 32'h0, 4'hF, 8'd3, 1'b0);
        checkOutput("cyc_before_reset", 32'(wb.WBm_CYC_o), 32'd1);
        #1 WBs_RST_i = 1'b1;
        #1;
        checkOutput("rst_cyc_drop", 32'(wb.WBm_CYC_o), 32'd0);
        checkOutput("rst_stb_drop", 32'(wb.WBm_STB_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        expQ.delete();
        repeat (2) @(posedge WBs_CLK_i);
        #1 WBs_RST_i = 1'b0;
        applyStimulus(1'b0, 9'h003, 32'h0, 4'hF, 8'd1, 1'b0);
        measureAccess(lat, stbc);
        checkOutput("post_reset_latency", 32'(lat), 32'd3);
        waitIdle();

        $display("[TB] randomized command stream");
        randomMode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(9);
            adr = (r < 6) ? 9'(r) : 9'(9'h100 + 9'(r));
            applyStimulus(1'($urandom_range(1)), adr, $urandom, 4'($urandom_range(15)),
                          8'($urandom_range(4)), 1'($urandom_range(1)));
        end
        waitIdle();
        randomMode = 1'b0;

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
